dm_responder: RTL and testbench

Data-memory responder: the memory end of the CPU load/store interface. It accepts one request at a time from the processor's memory stage over a valid/ready handshake and returns a response after a programmable latency. Writes are byte-enabled. It replaces the zero-latency data memory so that later stall and handshake logic can be exercised against a slow memory.

---
 rtl/dm_responder.sv | 110 +++++++++++
 tb/tb_dm_responder.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/dm_responder.sv
// Data-memory responder: one outstanding load/store at a time over a valid/ready
// handshake, with a fixed programmable latency and byte-enabled writes.
//
// state  | meaning
// IDLE   | ready to accept a request (req_ready=1 once out of reset)
// BUSY   | request latched, latency down-counter running
// RESP   | response held on resp_* until resp_ready
module dm_responder #(
  parameter int ADDR_WIDTH = 12,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

  state_t state, next_state;

  logic [3:0]  cnt;
  logic        we_q;
  logic [29:0] waddr_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;

  logic [31:0] mem [0:DEPTH-1];

  logic [ADDR_WIDTH-1:0] idx;
  logic                  range_err;
  logic                  accept;
  logic                  execute;
  logic                  unused_addr;

  assign unused_addr = ^req_addr[1:0];
  assign idx         = waddr_q[ADDR_WIDTH-1:0];
  assign range_err   = |waddr_q[29:ADDR_WIDTH];

  // Gated with reset so the block never advertises readiness while held in reset.
  assign req_ready = (state == S_IDLE) && reset;
  assign accept    = req_valid && req_ready;
  assign execute   = (state == S_BUSY) && (cnt == 4'd0);

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (accept) next_state = S_BUSY;
      S_BUSY:  if (cnt == 4'd0) next_state = S_RESP;
      S_RESP:  if (resp_ready) next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      cnt        <= 4'd0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      be_q       <= 4'd0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      state <= next_state;
      if (accept) begin
        we_q    <= req_we;
        waddr_q <= req_addr[31:2];
        wdata_q <= req_wdata;
        be_q    <= req_be;
        cnt     <= LAT_M1;
      end else if (state == S_BUSY && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end

      if (execute) begin
        resp_valid <= 1'b1;
        resp_err   <= range_err;
        resp_rdata <= (range_err || we_q) ? 32'd0 : mem[idx];
      end else if (state == S_RESP && resp_ready) begin
        resp_valid <= 1'b0;
        resp_err   <= 1'b0;
        resp_rdata <= '0;
      end
    end
  end

  // Storage is deliberately not reset; only committed, in-range stores touch it.
  always_ff @(posedge clk) begin
    if (execute && we_q && !range_err) begin
      for (int i = 0; i < 4; i++) begin
        if (be_q[i]) mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dm_responder.sv
// Scoreboard bench for dm_responder: the driver pushes expected responses,
// a negedge monitor pops and compares them on each response handshake.
module tb_dm_responder;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  dm_responder #(.ADDR_WIDTH(12), .LATENCY(LAT)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_be     (req_be),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int acc_cyc = 0;

  logic [32:0] exp_q[$];
  logic        vprev = 1'b0;
  logic        hs_prev = 1'b0;
  logic [31:0] hold_rdata;
  logic        hold_err;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  // Monitor: samples mid-cycle, so a handshake seen here completes on the next rising edge.
  always @(negedge clk) begin
    if (reset !== 1'b1) begin
      vprev   = 1'b0;
      hs_prev = 1'b0;
    end else begin
      if (req_valid && req_ready) acc_cyc = cyc + 1;
      if (resp_valid) begin
        if (!vprev) check("latency", 32'(cyc - acc_cyc), 32'(LAT));
        else if (!hs_prev) begin
          check("hold_rdata", resp_rdata, hold_rdata);
          check("hold_err", {31'd0, resp_err}, {31'd0, hold_err});
        end
        check("ready_in_resp", {31'd0, req_ready}, 32'd0);
        if (resp_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_resp", 32'd1, 32'd0);
          end else begin
            logic [32:0] e;
            e = exp_q.pop_front();
            check("rdata", resp_rdata, e[32:1]);
            check("err", {31'd0, resp_err}, {31'd0, e[0]});
          end
        end
      end
      vprev      = resp_valid;
      hs_prev    = resp_valid && resp_ready;
      hold_rdata = resp_rdata;
      hold_err   = resp_err;
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) check("ready_timeout", 32'd0, 32'd1);
  endtask

  // Issue one request starting at a negedge; scrambles request inputs after accept.
  task automatic send(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                      input logic [3:0] be, input logic [31:0] erd, input logic eerr);
    wait_ready();
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wd;
    req_be    = be;
    exp_q.push_back({erd, eerr});
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_we    = ~we;
    req_addr  = 32'h0000_0FF0;
    req_wdata = 32'hA5A5_A5A5;
    req_be    = 4'hF;
    @(negedge clk);
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || !req_ready) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    reset      = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    req_be     = '0;
    resp_ready = 1'b1;

    // Reset: all outputs low while held
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_outputs", {resp_rdata}, 32'd0);
      check("rst_flags", {29'd0, req_ready, resp_valid, resp_err}, 32'd0);
    end
    reset = 1'b1;
    @(negedge clk);
    check("ready_after_rst", {31'd0, req_ready}, 32'd1);
    check("valid_after_rst", {31'd0, resp_valid}, 32'd0);

    // Full-word store/load, plus a known value at word 0
    send(1'b1, 32'h0000_0010, 32'h1234_5678, 4'b1111, 32'd0, 1'b0);
    send(1'b1, 32'h0000_0000, 32'h0BAD_F00D, 4'b1111, 32'd0, 1'b0);
    send(1'b0, 32'h0000_0010, 32'h0, 4'b0000, 32'h1234_5678, 1'b0);

    // Byte-lane store, low address bits ignored
    send(1'b1, 32'h0000_0010, 32'h0000_AB00, 4'b0010, 32'd0, 1'b0);
    send(1'b0, 32'h0000_0010, 32'h0, 4'b1111, 32'h1234_AB78, 1'b0);
    send(1'b0, 32'h0000_0013, 32'h0, 4'b0000, 32'h1234_AB78, 1'b0);

    // be=0000 store is a no-op with a normal response
    send(1'b1, 32'h0000_0010, 32'hFFFF_FFFF, 4'b0000, 32'd0, 1'b0);
    send(1'b0, 32'h0000_0010, 32'h0, 4'b0000, 32'h1234_AB78, 1'b0);
    drain();

    // Backpressure: held response, competing request waits until RESP clears
    resp_ready = 1'b0;
    send(1'b0, 32'h0000_0010, 32'h0, 4'b0000, 32'h1234_AB78, 1'b0);
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 32'h0000_0000;
    exp_q.push_back({32'h0BAD_F00D, 1'b0});
    begin
      int n = 0;
      while (!resp_valid && n < 50) begin
        @(negedge clk);
        n++;
      end
    end
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", {31'd0, resp_valid}, 32'd1);
      check("bp_ready", {31'd0, req_ready}, 32'd0);
      @(negedge clk);
    end
    resp_ready = 1'b1;
    wait_ready();
    check("accept_after_resp", {31'd0, resp_valid}, 32'd0);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    drain();

    // Out-of-range store: error, no write
    send(1'b1, 32'h0000_4000, 32'hDEAD_BEEF, 4'b1111, 32'd0, 1'b1);
    send(1'b0, 32'h0000_0000, 32'h0, 4'b1111, 32'h0BAD_F00D, 1'b0);
    send(1'b0, 32'h8000_0010, 32'h0, 4'b1111, 32'd0, 1'b1);

    // Reset while a store is still counting drops it
    send(1'b1, 32'h0000_0020, 32'h1111_2222, 4'b1111, 32'd0, 1'b0);
    drain();
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 32'h0000_0020;
    req_wdata = 32'hCAFE_F00D;
    req_be    = 4'b1111;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_mid_valid", {31'd0, resp_valid}, 32'd0);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("no_resp_after_rst", {31'd0, resp_valid}, 32'd0);
    end
    send(1'b0, 32'h0000_0020, 32'h0, 4'b0000, 32'h1111_2222, 1'b0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
